// File: rtl/pb_event_gen_pkg.sv
// Shared UI definitions: FSM state encoding and default tick constants
// for the push-button event blocks.
package pb_event_gen_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        LONG  = 2'd2
    } pb_state_t;

    localparam int CNT_W_DEF        = 8;
    localparam int LONG_TICKS_DEF   = 100;
    localparam int REPEAT_TICKS_DEF = 20;

endpackage

// File: rtl/pb_edge_det.sv
// Level-to-edge detector: registers the level and flags rising/falling
// transitions against the previous sample.
module pb_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise,
    output logic fall
);

    logic level_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign rise = level & ~level_q;
    assign fall = ~level & level_q;

endmodule

// File: rtl/pb_event_gen.sv
// Turns a debounced button level into single-cycle press/release/short/long
// and auto-repeat events, with hold timing counted in timebase ticks.
module pb_event_gen
    import pb_event_gen_pkg::*;
#(
    parameter int CNT_W        = CNT_W_DEF,
    parameter int LONG_TICKS   = LONG_TICKS_DEF,
    parameter int REPEAT_TICKS = REPEAT_TICKS_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic pb_debounced,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_press,
    output logic long_press,
    output logic repeat_pulse,
    output logic held
);

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);

    pb_state_t        state;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] rep_cnt;
    logic             rise;
    logic             fall;

    pb_edge_det u_edge (
        .clk   (clk),
        .rst   (rst),
        .level (pb_debounced),
        .rise  (rise),
        .fall  (fall)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            hold_cnt      <= '0;
            rep_cnt       <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_press   <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;
            held          <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_press   <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;

            case (state)
                IDLE: begin
                    hold_cnt <= '0;
                    rep_cnt  <= '0;
                    if (rise) begin
                        press_pulse <= 1'b1;
                        held        <= 1'b1;
                        state       <= PRESS;
                    end
                end
                PRESS: begin
                    // A release always takes priority over a coincident tick.
                    if (fall) begin
                        release_pulse <= 1'b1;
                        short_press   <= 1'b1;
                        held          <= 1'b0;
                        hold_cnt      <= '0;
                        rep_cnt       <= '0;
                        state         <= IDLE;
                    end else if (tick) begin
                        if (hold_cnt == LONG_LAST) begin
                            long_press <= 1'b1;
                            rep_cnt    <= '0;
                            state      <= LONG;
                        end else begin
                            hold_cnt <= hold_cnt + CNT_W'(1);
                        end
                    end
                end
                LONG: begin
                    if (fall) begin
                        release_pulse <= 1'b1;
                        held          <= 1'b0;
                        hold_cnt      <= '0;
                        rep_cnt       <= '0;
                        state         <= IDLE;
                    end else if (tick) begin
                        if (rep_cnt == REPEAT_LAST) begin
                            repeat_pulse <= 1'b1;
                            rep_cnt      <= '0;
                        end else begin
                            rep_cnt <= rep_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    held     <= 1'b0;
                    hold_cnt <= '0;
                    rep_cnt  <= '0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
